// File: rtl/led_pkg.sv
// Shared types for the LED bank arbiter.
// Holds the LED width and the arbiter state encoding.
package led_pkg;

  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    URGENT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req after ptr, ptr itself last.
// Ports: req, ptr in; valid (any req), idx (winner) out.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [W-1:0] j;

  // Scan in reverse order so the last hit is the earliest in RR order.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Time-slice round-robin sharing of the LED bank, with urgent override.
// Ports: clk_25mhz, rst_n, req, pat, urgent, urgent_pat in; grant, led, active out.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int SLOT_CYCLES = 25_000_000
) (
  input  logic                  clk_25mhz,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] pat,
  input  logic                  urgent,
  input  logic [LED_W-1:0]      urgent_pat,
  output logic [NREQ-1:0]       grant,
  output logic [LED_W-1:0]      led,
  output logic                  active
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] CNT_RLD = CW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic              held_q, held_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic              pick_valid;
  logic [PW-1:0]     pick_idx;
  logic              take_pick;

  rr_pick #(
    .N (NREQ),
    .W (PW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    held_d    = held_q;
    take_pick = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (urgent) begin
          state_d = URGENT;
          held_d  = 1'b0;
        end else begin
          take_pick = 1'b1;
        end
      end
      HOLD: begin
        // held_d marks a preempted slot that may resume on urgent exit
        if (urgent) begin
          state_d = URGENT;
          held_d  = 1'b1;
        end else if (cnt_q == '0 || !req[idx_q]) begin
          take_pick = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      URGENT: begin
        if (!urgent) begin
          if (held_q && req[idx_q]) state_d = HOLD;
          else take_pick = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take_pick) begin
      if (pick_valid) begin
        state_d = HOLD;
        idx_d   = pick_idx;
        ptr_d   = pick_idx;
        cnt_d   = CNT_RLD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // Outputs follow the next state so grant and led switch together.
  always_comb begin
    grant_d = '0;
    led_d   = '0;
    if (state_d == HOLD) begin
      grant_d = ONE << idx_d;
      led_d   = pat[idx_d*LED_W +: LED_W];
    end else if (state_d == URGENT) begin
      led_d = urgent_pat;
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
      idx_q   <= '0;
      held_q  <= 1'b0;
      grant_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

  assign grant  = grant_q;
  assign led    = led_q;
  assign active = (state_q != IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scoreboard bench for led_bank_arbiter (NREQ=4, SLOT_CYCLES=4).
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_led_bank_arbiter;

  typedef struct {
    int         tag;
    logic [3:0] g;
    logic [7:0] l;
    logic       a;
  } exp_t;

  logic        clk_25mhz = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] pat = 32'hC35A3CA5;
  logic        urgent = 1'b0;
  logic [7:0]  urgent_pat = '0;
  logic [3:0]  grant;
  logic [7:0]  led;
  logic        active;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  led_bank_arbiter #(
    .NREQ        (4),
    .SLOT_CYCLES (4)
  ) dut (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .req        (req),
    .pat        (pat),
    .urgent     (urgent),
    .urgent_pat (urgent_pat),
    .grant      (grant),
    .led        (led),
    .active     (active)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  task automatic check(input int tag, input logic [3:0] g,
                       input logic [7:0] l, input logic a);
    n_cmp++;
    if (grant !== g || led !== l || active !== a) begin
      n_bad++;
      $display("FAIL tag=%0d got grant=%b led=%h active=%b want grant=%b led=%h active=%b",
               tag, grant, led, active, g, l, a);
    end
  endtask

  // One clock: expectation for the coming edge, then wait for next negedge.
  task automatic cyc(input int tag, input logic [3:0] g,
                     input logic [7:0] l, input logic a);
    exp_t e;
    e.tag = tag; e.g = g; e.l = l; e.a = a;
    q.push_back(e);
    @(negedge clk_25mhz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_25mhz);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, e.g, e.l, e.a);
      end
    end
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    #4 check(0, 4'b0000, 8'h00, 1'b0);
    @(negedge clk_25mhz);
    rst_n = 1'b1;

    // two requesters alternate from reset pointer
    req = 4'b0101;
    for (int i = 0; i < 4; i++) cyc(20, 4'b0001, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) cyc(21, 4'b0100, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) cyc(22, 4'b0001, 8'hA5, 1'b1);
    req = 4'b0000;
    cyc(23, 4'b0000, 8'h00, 1'b0);

    // sole requester, re-granted; led tracks pattern change
    req = 4'b0001;
    cyc(10, 4'b0001, 8'hA5, 1'b1);
    cyc(10, 4'b0001, 8'hA5, 1'b1);
    pat[7:0] = 8'h81;
    for (int i = 0; i < 4; i++) cyc(11, 4'b0001, 8'h81, 1'b1);
    pat[7:0] = 8'hA5;
    req = 4'b0000;
    cyc(12, 4'b0000, 8'h00, 1'b0);

    // request drop mid-slot, then reload check
    req = 4'b1010;
    cyc(30, 4'b0010, 8'h3C, 1'b1);
    cyc(30, 4'b0010, 8'h3C, 1'b1);
    req = 4'b1000;
    cyc(31, 4'b1000, 8'hC3, 1'b1);
    req = 4'b1001;
    for (int i = 0; i < 3; i++) cyc(31, 4'b1000, 8'hC3, 1'b1);
    cyc(32, 4'b0001, 8'hA5, 1'b1);
    cyc(32, 4'b0001, 8'hA5, 1'b1);

    // urgent preempts source 0 at cnt=2, then resumes 3 cycles
    urgent = 1'b1;
    urgent_pat = 8'hFF;
    for (int i = 0; i < 5; i++) cyc(40, 4'b0000, 8'hFF, 1'b1);
    urgent_pat = 8'h0F;
    for (int i = 0; i < 5; i++) cyc(41, 4'b0000, 8'h0F, 1'b1);
    urgent = 1'b0;
    for (int i = 0; i < 3; i++) cyc(42, 4'b0001, 8'hA5, 1'b1);
    cyc(43, 4'b1000, 8'hC3, 1'b1);

    // all requests drop
    req = 4'b0000;
    cyc(50, 4'b0000, 8'h00, 1'b0);

    // async reset mid-slot
    req = 4'b0001;
    cyc(60, 4'b0001, 8'hA5, 1'b1);
    cyc(60, 4'b0001, 8'hA5, 1'b1);
    #5 rst_n = 1'b0;
    #1 check(61, 4'b0000, 8'h00, 1'b0);
    @(negedge clk_25mhz);
    check(62, 4'b0000, 8'h00, 1'b0);
    req = 4'b0010;
    rst_n = 1'b1;
    cyc(63, 4'b0010, 8'h3C, 1'b1);
    req = 4'b0000;
    cyc(64, 4'b0000, 8'h00, 1'b0);

    // pointer returns to NREQ-1: with 0011, source 0 wins
    req = 4'b0001;
    cyc(65, 4'b0001, 8'hA5, 1'b1);
    #5 rst_n = 1'b0;
    @(negedge clk_25mhz);
    req = 4'b0011;
    rst_n = 1'b1;
    cyc(66, 4'b0001, 8'hA5, 1'b1);
    req = 4'b0000;
    cyc(67, 4'b0000, 8'h00, 1'b0);

    @(negedge clk_25mhz);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
